// File: rtl/mem_pkg.sv
// Shared encodings for the data memory: RV32 load/store funct3 codes and dump FSM states.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dump_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte/half lane extraction with sign/zero extension for loads, and lane merge for stores.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_byte_off,
    input  logic [DATA_W-1:0] i_mem_word,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_load_data,
    output logic [DATA_W-1:0] o_store_word,
    output logic              o_misaligned,
    output logic              o_load_ok,
    output logic              o_store_ok
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_mem_word[{i_byte_off, 3'b000} +: 8];
    assign w_half = i_mem_word[{i_byte_off[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        o_load_data  = '0;
        o_store_word = i_mem_word;
        o_misaligned = 1'b0;
        o_load_ok    = 1'b0;
        o_store_ok   = 1'b0;
        unique case (i_funct3)
            F3_B: begin
                o_load_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
                o_store_word[{i_byte_off, 3'b000} +: 8] = i_wdata[7:0];
                o_load_ok   = 1'b1;
                o_store_ok  = 1'b1;
            end
            F3_H: begin
                o_misaligned = i_byte_off[0];
                o_load_data  = {{(DATA_W-16){w_half[15]}}, w_half};
                o_store_word[{i_byte_off[1], 4'b0000} +: 16] = i_wdata[15:0];
                o_load_ok    = 1'b1;
                o_store_ok   = 1'b1;
            end
            F3_W: begin
                o_misaligned = (i_byte_off != 2'b00);
                o_load_data  = i_mem_word;
                o_store_word = i_wdata;
                o_load_ok    = 1'b1;
                o_store_ok   = 1'b1;
            end
            F3_BU: begin
                o_load_data = {{(DATA_W-8){1'b0}}, w_byte};
                o_load_ok   = 1'b1;
            end
            F3_HU: begin
                o_misaligned = i_byte_off[0];
                o_load_data  = {{(DATA_W-16){1'b0}}, w_half};
                o_load_ok    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_dump.sv
// Word-organised data memory with RV32 byte/half/word access and a handshaked full-memory dump port.
module data_mem_dump
    import mem_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32   // only 32 is supported
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              misaligned,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [ADDR_W-1:0] w_idx;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_store_word;
    logic              w_misaligned;
    logic              w_load_ok;
    logic              w_store_ok;
    logic              w_store_en;
    logic              w_unused_addr;

    // Upper address bits are ignored so accesses wrap modulo the memory size.
    assign w_idx         = addr[ADDR_W+1:2];
    assign w_unused_addr = ^addr[31:ADDR_W+2];

    mem_lane_align #(.DATA_W(DATA_W)) u_lane_align (
        .i_funct3     (funct3),
        .i_byte_off   (addr[1:0]),
        .i_mem_word   (r_mem[w_idx]),
        .i_wdata      (wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word),
        .o_misaligned (w_misaligned),
        .o_load_ok    (w_load_ok),
        .o_store_ok   (w_store_ok)
    );

    assign misaligned = w_misaligned;
    assign w_store_en = mem_write && w_store_ok && !w_misaligned;
    assign rdata      = (mem_read && w_load_ok && !w_misaligned) ? w_load_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the array is built from flops, not a RAM macro, because reset must clear every word.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_store_en) begin
            r_mem[w_idx] <= w_store_word;
        end
    end

    dump_state_e       r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_dump_data;
    logic              r_dump_valid;
    logic              r_dump_busy;
    logic              r_dump_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_dump_data  <= '0;
            r_dump_valid <= 1'b0;
            r_dump_busy  <= 1'b0;
            r_dump_done  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (dump_start) begin
                        r_state     <= ST_LOAD;
                        r_idx       <= '0;
                        r_dump_busy <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // Reads the array before any same-cycle store lands, so a colliding store is not seen.
                    r_dump_data  <= r_mem[r_idx];
                    r_dump_valid <= 1'b1;
                    r_state      <= ST_SEND;
                end
                ST_SEND: begin
                    if (dump_ready) begin
                        r_dump_valid <= 1'b0;
                        if (r_idx == '1) begin
                            r_state     <= ST_DONE;
                            r_dump_done <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    r_dump_done <= 1'b0;
                    r_dump_busy <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dump_valid = r_dump_valid;
    assign dump_idx   = r_idx;
    assign dump_data  = r_dump_data;
    assign dump_busy  = r_dump_busy;
    assign dump_done  = r_dump_done;

endmodule

// File: tb/tb_data_mem_dump.sv
// Self-checking bench for data_mem_dump: lane access, merge, wrap, read/write overlap and dump handshake.
module tb_data_mem_dump;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101, BAD = 3'b011;

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [31:0]       data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_read, mem_write;
    logic [2:0]        funct3;
    logic [31:0]       addr, wdata, rdata;
    logic              misaligned;
    logic              dump_start, dump_valid, dump_ready, dump_busy, dump_done;
    logic [ADDR_W-1:0] dump_idx;
    logic [31:0]       dump_data;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    data_mem_dump #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .misaligned (misaligned),
        .dump_start (dump_start),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

    task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        mem_write = 1'b1;
        mem_read  = 1'b0;
        funct3    = f3;
        addr      = a;
        wdata     = d;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] a,
                           output logic [31:0] d, output logic m);
        mem_read  = 1'b1;
        mem_write = 1'b0;
        funct3    = f3;
        addr      = a;
        #1;
        d         = rdata;
        m         = misaligned;
        mem_read  = 1'b0;
    endtask

    task automatic pop_compare(input string name);
        exp_t e;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected transfer idx=%0d data=%h with empty scoreboard", name, dump_idx, dump_data);
        end else begin
            e = sb_q.pop_front();
            if ({dump_idx, dump_data} !== {e.idx, e.data}) begin
                bad++;
                $display("FAIL %s: got idx=%0d data=%h want idx=%0d data=%h", name, dump_idx, dump_data, e.idx, e.data);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        m;
        rst = 1'b1;
        mem_read = 0; mem_write = 0; funct3 = LW; addr = 0; wdata = 0;
        dump_start = 0; dump_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({dump_valid, dump_busy, dump_done, dump_idx, dump_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b b=%b d=%b idx=%0d data=%h want all 0",
                     dump_valid, dump_busy, dump_done, dump_idx, dump_data);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_load(LW, 32'h7C, d, m);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL reset_mem: got %h want 00000000", d);
        end
    endtask

    task automatic test_lanes();
        logic [31:0] d;
        logic        m;
        do_store(LW, 32'h08, 32'h8000_1234);
        do_load(LB, 32'h0B, d, m);
        total++; if (d !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_sext: got %h want ffffff80", d); end
        do_load(LBU, 32'h0B, d, m);
        total++; if (d !== 32'h0000_0080) begin bad++; $display("FAIL lbu_zext: got %h want 00000080", d); end
        do_load(LH, 32'h0A, d, m);
        total++; if (d !== 32'hFFFF_8000) begin bad++; $display("FAIL lh_sext: got %h want ffff8000", d); end
        do_load(LHU, 32'h0A, d, m);
        total++; if (d !== 32'h0000_8000) begin bad++; $display("FAIL lhu_zext: got %h want 00008000", d); end
        do_load(LB, 32'h08, d, m);
        total++; if (d !== 32'h0000_0034) begin bad++; $display("FAIL lb_lane0: got %h want 00000034", d); end
        do_load(LH, 32'h0B, d, m);
        total++; if ({m, d} !== {1'b1, 32'h0}) begin bad++; $display("FAIL lh_misaligned: got m=%b d=%h want m=1 d=0", m, d); end
        do_load(BAD, 32'h08, d, m);
        total++; if ({m, d} !== {1'b0, 32'h0}) begin bad++; $display("FAIL load_illegal: got m=%b d=%h want m=0 d=0", m, d); end
        mem_read = 1'b0; funct3 = LW; addr = 32'h08; #1;
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL no_read: got %h want 0", rdata); end
    endtask

    task automatic test_merge();
        logic [31:0] d;
        logic        m;
        do_store(LW, 32'h04, 32'h1122_3344);
        do_store(LH, 32'h06, 32'h0000_BEEF);
        do_load(LW, 32'h04, d, m);
        total++; if (d !== 32'hBEEF_3344) begin bad++; $display("FAIL sh_merge: got %h want beef3344", d); end
        do_store(LB, 32'h05, 32'hFFFF_FF77);
        do_load(LW, 32'h04, d, m);
        total++; if (d !== 32'hBEEF_7744) begin bad++; $display("FAIL sb_merge: got %h want beef7744", d); end
        mem_write = 1'b1; funct3 = LW; addr = 32'h05; wdata = 32'hDEAD_DEAD; #1;
        total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL sw_misaligned_flag: got %b want 1", misaligned); end
        @(posedge clk); #1; mem_write = 1'b0;
        do_store(BAD, 32'h04, 32'hCAFE_CAFE);
        do_load(LW, 32'h04, d, m);
        total++; if (d !== 32'hBEEF_7744) begin bad++; $display("FAIL store_suppressed: got %h want beef7744", d); end
    endtask

    task automatic test_wrap_and_overlap();
        logic [31:0] d;
        logic        m;
        do_store(LW, 32'h80, 32'h0000_00A5);
        do_load(LW, 32'h00, d, m);
        total++; if (d !== 32'h0000_00A5) begin bad++; $display("FAIL addr_wrap: got %h want 000000a5", d); end
        mem_read = 1'b1; mem_write = 1'b1; funct3 = LW; addr = 32'hFFFF_FF80; wdata = 32'h5A5A_5A5A; #1;
        total++; if (rdata !== 32'h0000_00A5) begin bad++; $display("FAIL rw_pre_store: got %h want 000000a5", rdata); end
        @(posedge clk); #1;
        mem_write = 1'b0;
        total++; if (rdata !== 32'h5A5A_5A5A) begin bad++; $display("FAIL rw_post_store: got %h want 5a5a5a5a", rdata); end
        mem_read = 1'b0;
    endtask

    task automatic fill_index();
        for (int i = 0; i < DEPTH; i++) begin
            do_store(LW, 32'(i * 4), 32'(i));
        end
    endtask

    task automatic test_dump_full();
        int   cyc = 0;
        int   n   = 0;
        logic seen_done = 1'b0;
        fill_index();
        sb_q.delete();
        for (int i = 0; i < DEPTH; i++) sb_q.push_back('{idx: ADDR_W'(i), data: 32'(i)});
        dump_ready = 1'b1;
        dump_start = 1'b1;
        while (cyc < 200 && !seen_done) begin
            @(posedge clk); #1;
            cyc++;
            dump_start = 1'b0;
            if (dump_done) seen_done = 1'b1;
            else if (dump_valid && dump_ready) begin pop_compare("full_xfer"); n++; end
        end
        total++;
        if (!seen_done) begin bad++; $display("FAIL full_timeout: got no dump_done within %0d cycles want done", cyc); end
        total++; if (cyc != 2 * DEPTH + 1) begin bad++; $display("FAIL full_latency: got %0d want %0d", cyc, 2 * DEPTH + 1); end
        total++; if (n != DEPTH) begin bad++; $display("FAIL full_count: got %0d want %0d", n, DEPTH); end
        @(posedge clk); #1;
        total++;
        if ({dump_done, dump_busy} !== 2'b00) begin
            bad++;
            $display("FAIL done_pulse: got done=%b busy=%b want 0 0", dump_done, dump_busy);
        end
    endtask

    task automatic test_dump_stall();
        int   cyc   = 0;
        int   n     = 0;
        int   stall = 0;
        logic seen_done = 1'b0;
        sb_q.delete();
        for (int i = 0; i < DEPTH; i++) sb_q.push_back('{idx: ADDR_W'(i), data: 32'(i)});
        dump_ready = 1'b1;
        dump_start = 1'b1;
        while (cyc < 200 && !seen_done) begin
            @(posedge clk); #1;
            cyc++;
            if (dump_done) begin
                seen_done  = 1'b1;
                dump_start = 1'b0;
            end else if (dump_valid && dump_idx == 5 && stall < 3) begin
                dump_ready = 1'b0;
                dump_start = 1'b1;
                stall++;
                total++;
                if ({dump_valid, dump_idx, dump_data} !== {1'b1, 5'd5, 32'd5}) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b idx=%0d data=%h want v=1 idx=5 data=5",
                             dump_valid, dump_idx, dump_data);
                end
            end else begin
                dump_ready = 1'b1;
                dump_start = 1'b0;
                if (dump_valid) begin pop_compare("stall_xfer"); n++; end
            end
        end
        total++;
        if (!seen_done) begin bad++; $display("FAIL stall_timeout: got no dump_done within %0d cycles want done", cyc); end
        total++; if (cyc != 2 * DEPTH + 4) begin bad++; $display("FAIL stall_latency: got %0d want %0d", cyc, 2 * DEPTH + 4); end
        total++; if (n != DEPTH || stall != 3) begin bad++; $display("FAIL stall_count: got n=%0d stall=%0d want %0d 3", n, stall, DEPTH); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int          cyc = 0;
        int          dones = 0;
        logic [31:0] d;
        logic        m;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        while (cyc < 100 && !(dump_valid && dump_idx == 10)) begin
            @(posedge clk); #1;
            cyc++;
            dump_start = 1'b0;
        end
        total++;
        if (!(dump_valid && dump_idx == 10)) begin bad++; $display("FAIL mid_reach: got idx=%0d want 10 presented", dump_idx); end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({dump_valid, dump_busy, dump_done, dump_idx, dump_data} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got v=%b b=%b d=%b idx=%0d data=%h want all 0",
                     dump_valid, dump_busy, dump_done, dump_idx, dump_data);
        end
        do_load(LW, 32'h28, d, m);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_reset_mem: got %h want 0", d); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (dump_done) dones++;
        end
        total++;
        if (dones != 0 || dump_busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_no_done: got dones=%0d busy=%b want 0 0", dones, dump_busy);
        end
    endtask

    initial begin
        test_reset();
        test_lanes();
        test_merge();
        test_wrap_and_overlap();
        test_dump_full();
        test_dump_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_dump.md
DATA_MEM_DUMP -- requirements
Module: data_mem_dump

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning word-index width; depth DEPTH = 2**ADDR_W words (32 by default).
REQ-002 SHALL have parameter DATA_W, default 32, meaning word width; only 32 is legal.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, named clk and rst as in the rest of the datapath.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 mem_read  input  1  load enable.
REQ-007 mem_write  input  1  store enable.
REQ-008 funct3  input  3  access size/sign (RV32 load/store encoding).
REQ-009 addr  input  32  byte address.
REQ-010 wdata  input  32  store data, low-aligned.
REQ-011 rdata  output  32  load result, combinational.
REQ-012 misaligned  output  1  current access is misaligned, combinational.
REQ-013 dump_start  input  1  request a full-memory dump.
REQ-014 dump_valid  output  1  dump word is presented.
REQ-015 dump_ready  input  1  consumer accepts the dump word.
REQ-016 dump_idx  output  ADDR_W  word index of dump_data.
REQ-017 dump_data  output  32  dumped word.
REQ-018 dump_busy  output  1  dump FSM is not in IDLE.
REQ-019 dump_done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-020 Word index SHALL be addr[ADDR_W+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo DEPTH*4.
REQ-021 Loads SHALL decode funct3 as 000 LB (sign-extend), 001 LH (sign-extend), 010 LW, 100 LBU (zero-extend), 101 LHU (zero-extend); the selected byte/half SHALL come from lane addr[1:0] / addr[1].
REQ-022 Stores SHALL decode funct3 as 000 SB, 001 SH, 010 SW; SB/SH SHALL modify only the addressed lanes on the rising clk edge.
REQ-023 misaligned SHALL be 1 for half accesses with addr[0]=1 and for word accesses with addr[1:0]!=0, and SHALL be 0 otherwise.
REQ-024 A misaligned or illegal-funct3 store SHALL be suppressed with no memory change.
REQ-025 rdata SHALL be 0 when mem_read=0, when the access is misaligned, or when funct3 is illegal.
REQ-026 If mem_read and mem_write are both 1, the store SHALL be performed and rdata SHALL show the pre-store contents.
REQ-027 Dump FSM states SHALL be IDLE, LOAD, SEND, DONE.
REQ-028 IDLE: dump_start=1 SHALL go to LOAD with idx=0; dump_start SHALL be ignored in every other state.
REQ-029 LOAD: dump_data SHALL register mem[idx]; the next state SHALL be SEND.
REQ-030 SEND: dump_valid SHALL be 1.
REQ-031 In SEND, dump_data and dump_idx SHALL hold stable while dump_ready=0.
REQ-032 In SEND with dump_ready=1: if idx=DEPTH-1, SHALL go to DONE; otherwise SHALL increment idx and go to LOAD.
REQ-033 DONE: dump_done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-034 A full dump with dump_ready held at 1 SHALL take 2*DEPTH+1 cycles from dump_start to dump_done.
REQ-035 Core loads and stores SHALL proceed unchanged during a dump.
REQ-036 A store to index k in the same cycle as LOAD of index k SHALL make LOAD capture the pre-store word.

Reset
REQ-037 rst=1 SHALL asynchronously clear all memory words to 0.
REQ-038 rst=1 SHALL force the FSM to IDLE with idx=0.
REQ-039 rst=1 SHALL force dump_valid, dump_busy, dump_done, dump_data and dump_idx to 0.
REQ-040 Reset during a dump SHALL abort it with no dump_done pulse.

Structure
REQ-041 funct3 load/store codes and the FSM state encodings SHALL live in the shared package mem_pkg.
REQ-042 Lane extraction/extension and store byte-merge SHALL be one combinational sub-module, mem_lane_align.

Verification
REQ-043 SW 0x80001234 @0x08, then LB/LBU @0x0B -> rdata 0xFFFFFF80 / 0x00000080; LH @0x0A -> 0xFFFF8000.
REQ-044 SH 0xBEEF @0x06 over word 0x11223344 @0x04 -> LW @0x04 reads 0xBEEF3344; SW @0x05 -> misaligned=1, word unchanged.
REQ-045 SW 0xA5 @0x80 with default ADDR_W -> LW @0x00 reads 0xA5 (address wrap).
REQ-046 Fill words with their index, dump with ready=1 -> 32 transfers, idx 0..31 with data=idx, dump_done at cycle 65 after start.
REQ-047 Dump with ready deasserted 3 cycles at idx 5 -> dump_valid, dump_idx=5 and dump_data held stable; a second dump_start while busy is ignored.
REQ-048 Assert rst mid-dump at idx 10 -> all outputs 0 immediately, memory reads 0, no dump_done.
